// File: rtl/audio_pkg.sv
// Shared audio constants and the capture state type, common to the speaker and receiver paths.
package audio_pkg;

  localparam int unsigned AUDIO_DATA_W        = 16;
  localparam int unsigned AUDIO_MCLK_DIV_LOG2 = 2;
  localparam int unsigned AUDIO_SCK_DIV_LOG2  = 3;
  localparam int unsigned AUDIO_LRCK_DIV_LOG2 = 9;
  localparam int unsigned AUDIO_PEAK_DECAY_W  = 8;

  typedef enum logic [1:0] {
    SYNC,
    LEFT,
    RIGHT
  } audio_state_e;

endpackage

// File: rtl/audio_receiver_if.sv
// Codec pins plus the stereo-frame output handshake of the audio receiver.
// Optional AUDIO_RX_PEAK_EN adds the peak_level signal.
interface audio_receiver_if #(
  parameter int unsigned DATA_W = audio_pkg::AUDIO_DATA_W
);

  logic              audio_sdout;
  logic              out_ready;
  logic              clear_ovr;
  logic              audio_mclk;
  logic              audio_lrck;
  logic              audio_sck;
  logic              out_valid;
  logic [DATA_W-1:0] out_left;
  logic [DATA_W-1:0] out_right;
  logic              overrun;
`ifdef AUDIO_RX_PEAK_EN
  logic [DATA_W-2:0] peak_level;

  modport master (
    input  audio_sdout, out_ready, clear_ovr,
    output audio_mclk, audio_lrck, audio_sck,
    output out_valid, out_left, out_right, overrun, peak_level
  );

  modport slave (
    output audio_sdout, out_ready, clear_ovr,
    input  audio_mclk, audio_lrck, audio_sck,
    input  out_valid, out_left, out_right, overrun, peak_level
  );
`else
  modport master (
    input  audio_sdout, out_ready, clear_ovr,
    output audio_mclk, audio_lrck, audio_sck,
    output out_valid, out_left, out_right, overrun
  );

  modport slave (
    output audio_sdout, out_ready, clear_ovr,
    input  audio_mclk, audio_lrck, audio_sck,
    input  out_valid, out_left, out_right, overrun
  );
`endif

endinterface

// File: rtl/audio_clk_gen.sv
// Free-running divider producing mclk/sck/lrck, the sck-rising bit strobe and the slot index.
module audio_clk_gen #(
  parameter int unsigned MCLK_DIV_LOG2 = audio_pkg::AUDIO_MCLK_DIV_LOG2,
  parameter int unsigned SCK_DIV_LOG2  = audio_pkg::AUDIO_SCK_DIV_LOG2,
  parameter int unsigned LRCK_DIV_LOG2 = audio_pkg::AUDIO_LRCK_DIV_LOG2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  output logic [LRCK_DIV_LOG2-1:0]              cnt,
  output logic                                  mclk,
  output logic                                  sck,
  output logic                                  lrck,
  output logic                                  bit_stb_c,
  output logic [LRCK_DIV_LOG2-SCK_DIV_LOG2-2:0] slot_c
);

  localparam int unsigned CNT_W     = LRCK_DIV_LOG2;
  localparam int unsigned STB_PHASE = 2 ** (SCK_DIV_LOG2 - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Clocks are plain counter bits, so they are registered and glitch-free.
  assign cnt       = cnt_q;
  assign mclk      = cnt_q[MCLK_DIV_LOG2-1];
  assign sck       = cnt_q[SCK_DIV_LOG2-1];
  assign lrck      = cnt_q[LRCK_DIV_LOG2-1];
  assign bit_stb_c = (cnt_q[SCK_DIV_LOG2-1:0] == SCK_DIV_LOG2'(STB_PHASE));
  assign slot_c    = cnt_q[LRCK_DIV_LOG2-2:SCK_DIV_LOG2];

endmodule

// File: rtl/audio_receiver.sv
// I2S capture from the audio Pmod ADC into a one-entry stereo-frame buffer with overrun flag.
// Optional AUDIO_RX_PEAK_EN adds a decaying peak-level meter.
module audio_receiver
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W        = AUDIO_DATA_W,
  parameter int unsigned MCLK_DIV_LOG2 = AUDIO_MCLK_DIV_LOG2,
  parameter int unsigned SCK_DIV_LOG2  = AUDIO_SCK_DIV_LOG2,
  parameter int unsigned LRCK_DIV_LOG2 = AUDIO_LRCK_DIV_LOG2
) (
  input  logic             clk,
  input  logic             rst,
  audio_receiver_if.master bus
);

  localparam int unsigned    CNT_W    = LRCK_DIV_LOG2;
  localparam int unsigned    SLOT_W   = LRCK_DIV_LOG2 - 1 - SCK_DIV_LOG2;
  localparam logic [CNT_W-1:0] CNT_HALF = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  if ((2 ** SLOT_W) < (DATA_W + 1)) begin : g_bad_div
    $error("audio_receiver: half-frame too short for DATA_W+1 sck slots");
  end

  logic [CNT_W-1:0]  cnt_c;
  logic              bit_stb_c;
  logic [SLOT_W-1:0] slot_c;

  audio_clk_gen #(
    .MCLK_DIV_LOG2 (MCLK_DIV_LOG2),
    .SCK_DIV_LOG2  (SCK_DIV_LOG2),
    .LRCK_DIV_LOG2 (LRCK_DIV_LOG2)
  ) u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .cnt       (cnt_c),
    .mclk      (bus.audio_mclk),
    .sck       (bus.audio_sck),
    .lrck      (bus.audio_lrck),
    .bit_stb_c (bit_stb_c),
    .slot_c    (slot_c)
  );

  audio_state_e      state_q, state_d;
  logic [DATA_W-1:0] left_sr_q, left_sr_d;
  logic [DATA_W-1:0] right_sr_q, right_sr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_left_q, out_left_d;
  logic [DATA_W-1:0] out_right_q, out_right_d;
  logic              overrun_q, overrun_d;
  logic              in_slot_c;
  logic              frame_done_c;
  logic [DATA_W-1:0] right_word_c;

  // Slot 0 is the I2S one-bit delay; slots past DATA_W carry nothing.
  assign in_slot_c    = bit_stb_c && (slot_c >= SLOT_W'(1)) && (slot_c <= SLOT_W'(DATA_W));
  assign right_word_c = {right_sr_q[DATA_W-2:0], bus.audio_sdout};

  always_comb begin
    state_d      = state_q;
    left_sr_d    = left_sr_q;
    right_sr_d   = right_sr_q;
    out_valid_d  = out_valid_q;
    out_left_d   = out_left_q;
    out_right_d  = out_right_q;
    overrun_d    = overrun_q;
    frame_done_c = 1'b0;

    case (state_q)
      SYNC: begin
        if (cnt_c == '0) state_d = LEFT;
      end
      LEFT: begin
        if (in_slot_c) left_sr_d = {left_sr_q[DATA_W-2:0], bus.audio_sdout};
        if (cnt_c == CNT_HALF) state_d = RIGHT;
      end
      RIGHT: begin
        if (in_slot_c) right_sr_d = right_word_c;
        if (bit_stb_c && (slot_c == SLOT_W'(DATA_W))) frame_done_c = 1'b1;
        if (cnt_c == CNT_LAST) state_d = LEFT;
      end
      default: state_d = SYNC;
    endcase

    // A drop in the same cycle as clear_ovr leaves the flag set.
    if (bus.clear_ovr) overrun_d = 1'b0;
    if (frame_done_c) begin
      if (!out_valid_q || bus.out_ready) begin
        out_valid_d = 1'b1;
        out_left_d  = left_sr_q;
        out_right_d = right_word_c;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SYNC;
      left_sr_q   <= '0;
      right_sr_q  <= '0;
      out_valid_q <= 1'b0;
      out_left_q  <= '0;
      out_right_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      left_sr_q   <= left_sr_d;
      right_sr_q  <= right_sr_d;
      out_valid_q <= out_valid_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_left  = out_left_q;
  assign bus.out_right = out_right_q;
  assign bus.overrun   = overrun_q;

`ifdef AUDIO_RX_PEAK_EN
  logic [DATA_W-2:0]             peak_q, peak_d;
  logic [AUDIO_PEAK_DECAY_W-1:0] decay_q, decay_d;
  logic [DATA_W-2:0]             abs_l_c, abs_r_c;

  // Magnitude with the most negative code saturated to full scale.
  function automatic logic [DATA_W-2:0] abs_sat(input logic [DATA_W-1:0] x);
    if (!x[DATA_W-1])                          return x[DATA_W-2:0];
    else if (x == {1'b1, {(DATA_W-1){1'b0}}})  return '1;
    else                                       return (DATA_W-1)'(~x + DATA_W'(1));
  endfunction

  assign abs_l_c = abs_sat(left_sr_q);
  assign abs_r_c = abs_sat(right_word_c);

  always_comb begin
    peak_d  = peak_q;
    decay_d = decay_q;
    if (cnt_c == CNT_LAST) begin
      decay_d = decay_q + AUDIO_PEAK_DECAY_W'(1);
      if (decay_q == '1) peak_d = peak_q - (peak_q >> 3);
    end
    if (frame_done_c) begin
      if (abs_l_c > peak_d) peak_d = abs_l_c;
      if (abs_r_c > peak_d) peak_d = abs_r_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_q  <= '0;
      decay_q <= '0;
    end else begin
      peak_q  <= peak_d;
      decay_q <= decay_d;
    end
  end

  assign bus.peak_level = peak_q;
`endif

endmodule

// File: tb/tb_audio_receiver.sv
// Directed bench for audio_receiver: bench-side I2S codec model, frame vector table, corner sequences.
module tb_audio_receiver;
  import audio_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  audio_receiver_if #(.DATA_W(16)) bus();

  audio_receiver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference frame position, independent of the DUT.
  logic [8:0] tb_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cnt <= '0;
    else     tb_cnt <= tb_cnt + 9'd1;
  end

  logic [15:0] frame_l = '0;
  logic [15:0] frame_r = '0;
  logic        fill    = 1'b0;
  int checks = 0;
  int errors = 0;

  // Codec: changes data after sck falls; slots 1..16 carry MSB..LSB, others carry fill.
  initial begin : codec
    int          idx;
    logic [15:0] w;
    bus.audio_sdout = 1'b0;
    forever begin
      @(negedge clk);
      idx = int'(tb_cnt[7:3]);
      w   = tb_cnt[8] ? frame_r : frame_l;
      if (idx >= 1 && idx <= 16) bus.audio_sdout = w[16-idx];
      else                       bus.audio_sdout = fill;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t cnt=%0d)", name, act, exp, $time, tb_cnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("clk_outputs", {29'd0, bus.audio_lrck, bus.audio_sck, bus.audio_mclk},
        {29'd0, tb_cnt[8], tb_cnt[2], tb_cnt[1]});
  endtask

  task automatic wait_cnt(input logic [8:0] t);
    int n = 0;
    while (tb_cnt != t && n < 600) begin
      tick();
      n++;
    end
    if (tb_cnt != t) begin
      checks++;
      errors++;
      $display("FAIL wait_cnt: got cnt %0d expected %0d", tb_cnt, t);
    end
  endtask

  task automatic chk_out(input string name, input logic v, input logic [15:0] l,
                         input logic [15:0] r, input logic o);
    chk({name, "_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    chk({name, "_left"},  {16'd0, bus.out_left},  {16'd0, l});
    chk({name, "_right"}, {16'd0, bus.out_right}, {16'd0, r});
    chk({name, "_ovr"},   {31'd0, bus.overrun},   {31'd0, o});
  endtask

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        fill;
    logic        rdy;
    logic        exp_v;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    logic        exp_o;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int pulses;
    // I2S pattern with dirty pad slots, then A/B/C with the consumer stalled.
    vecs[0] = '{16'h8001, 16'h7FFE, 1'b1, 1'b1, 1'b1, 16'h8001, 16'h7FFE, 1'b0};
    vecs[1] = '{16'h1234, 16'hABCD, 1'b1, 1'b0, 1'b1, 16'h1234, 16'hABCD, 1'b0};
    vecs[2] = '{16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 1'b1, 16'h1234, 16'hABCD, 1'b1};
    vecs[3] = '{16'h5A5A, 16'hA5A5, 1'b1, 1'b0, 1'b1, 16'h1234, 16'hABCD, 1'b1};

    bus.out_ready = 1'b1;
    bus.clear_ovr = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_out("reset", 1'b0, 16'h0, 16'h0, 1'b0);
    chk("reset_clks", {29'd0, bus.audio_lrck, bus.audio_sck, bus.audio_mclk}, 32'd0);
`ifdef AUDIO_RX_PEAK_EN
    chk("reset_peak", {17'd0, bus.peak_level}, 32'd0);
`endif
    rst = 1'b0;

    // Idle silence: first frame lands at cnt 389, then one pulse per frame.
    wait_cnt(9'd388);
    chk("first_valid_early", {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk_out("idle", 1'b1, 16'h0, 16'h0, 1'b0);
    pulses = 0;
    repeat (512) begin
      tick();
      if (bus.out_valid) pulses++;
    end
    chk("valid_per_frame", 32'(pulses), 32'd1);
    wait_cnt(9'd392);

    for (int i = 0; i < 4; i++) begin
      frame_l       = vecs[i].l;
      frame_r       = vecs[i].r;
      fill          = vecs[i].fill;
      bus.out_ready = vecs[i].rdy;
      wait_cnt(9'd389);
      chk_out($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_l, vecs[i].exp_r, vecs[i].exp_o);
      wait_cnt(9'd392);
    end

    // Release backpressure: A is taken, overrun stays until cleared.
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk_out("accept_a", 1'b0, 16'h1234, 16'hABCD, 1'b1);
    bus.clear_ovr = 1'b1;
    tick();
    bus.clear_ovr = 1'b0;
    chk("clear_ovr", {31'd0, bus.overrun}, 32'd0);

    // Accept in the completion cycle: D leaves, E loads, no overrun.
    frame_l = 16'h1111;
    frame_r = 16'h2222;
    wait_cnt(9'd389);
    chk_out("load_d", 1'b1, 16'h1111, 16'h2222, 1'b0);
    wait_cnt(9'd392);
    frame_l = 16'h3333;
    frame_r = 16'h4444;
    wait_cnt(9'd388);
    chk_out("hold_d", 1'b1, 16'h1111, 16'h2222, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk_out("swap_e", 1'b1, 16'h3333, 16'h4444, 1'b0);
    tick();
    chk_out("hold_e", 1'b1, 16'h3333, 16'h4444, 1'b0);

    // Drop F so overrun is set going into the reset.
    wait_cnt(9'd392);
    frame_l = 16'h7777;
    frame_r = 16'h8888;
    wait_cnt(9'd389);
    chk_out("drop_f", 1'b1, 16'h3333, 16'h4444, 1'b1);

    // Reset in the right half of a frame; only the post-reset frame may appear.
    wait_cnt(9'd392);
    frame_l = 16'h9999;
    frame_r = 16'h6666;
    wait_cnt(9'd300);
    rst = 1'b1;
    #1;
    chk_out("midreset", 1'b0, 16'h0, 16'h0, 1'b0);
    chk("midreset_clks", {29'd0, bus.audio_lrck, bus.audio_sck, bus.audio_mclk}, 32'd0);
    frame_l = 16'h8000;
    frame_r = 16'h0001;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_cnt(9'd388);
    chk("post_reset_early", {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk_out("post_reset", 1'b1, 16'h8000, 16'h0001, 1'b0);
`ifdef AUDIO_RX_PEAK_EN
    chk("peak_sat", {17'd0, bus.peak_level}, 32'h7FFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
